analyzer_batch_controller: RTL and testbench

- Sequencer between an upstream number stream and number_analyzer.
- Accepts 32-bit numbers over a valid/ready handshake and drives the analyzer's in_number/enable.
- Waits for the analyzer's out_ready, then captures is_odd/is_fibonacci/is_palindrome.
- Emits a one-cycle result record and keeps saturating per-property statistics counters, with a timeout guard against a hung analyzer.

---
 rtl/analyzer_batch_controller.sv | 167 ++++++++++++++++
 tb/tb_analyzer_batch_controller.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/analyzer_batch_controller.sv
// analyzer_batch_controller
//   Sequencer between an upstream number stream and a number_analyzer.
//   Accepts one 32-bit number per request over valid/ready, holds it on
//   an_number with an_enable high until the analyzer raises an_ready (or a
//   timeout expires), then emits a one-cycle result record and updates
//   saturating per-property statistics counters.
//
// Ports
//   clock, reset          : clock, synchronous active-high reset
//   in_valid/in_number    : upstream number, in_ready = accept this cycle
//   clear_counts          : synchronous clear of all statistics counters
//   an_number/an_enable   : request to the analyzer
//   an_ready, an_is_*     : analyzer completion and result flags
//   res_valid             : one-cycle record pulse
//   res_number/res_flags  : record payload, flags = {pal, fib, odd}
//   res_timeout           : record produced by timeout (flags forced 000)
//   busy                  : controller not in IDLE
//   cnt_*                 : saturating statistics counters

// Saturating counter lane with a clear that dominates increment.
module abc_sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);
  always_ff @(posedge clock) begin
    if (reset || clear)
      count <= '0;
    else if (inc && (count != {CNT_WIDTH{1'b1}}))
      count <= count + 1'b1;
  end
endmodule

module analyzer_batch_controller #(
  parameter int TIMEOUT_CYCLES = 1024,  // must be >= 2
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [31:0]          in_number,
  output logic                 in_ready,
  input  logic                 clear_counts,
  output logic [31:0]          an_number,
  output logic                 an_enable,
  input  logic                 an_ready,
  input  logic                 an_is_odd,
  input  logic                 an_is_fibonacci,
  input  logic                 an_is_palindrome,
  output logic                 res_valid,
  output logic [31:0]          res_number,
  output logic [2:0]           res_flags,
  output logic                 res_timeout,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] cnt_total,
  output logic [CNT_WIDTH-1:0] cnt_odd,
  output logic [CNT_WIDTH-1:0] cnt_fib,
  output logic [CNT_WIDTH-1:0] cnt_pal,
  output logic [CNT_WIDTH-1:0] cnt_timeout
);

  localparam int TW        = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int NUM_LANES = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;

  wire timer_expired = (timer == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      in_ready    <= 1'b1;
      busy        <= 1'b0;
      an_enable   <= 1'b0;
      an_number   <= '0;
      res_valid   <= 1'b0;
      res_number  <= '0;
      res_flags   <= '0;
      res_timeout <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            an_number  <= in_number;
            res_number <= in_number;
            timer      <= '0;
            in_ready   <= 1'b0;
            busy       <= 1'b1;
            an_enable  <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          // A result arriving on the final timer cycle still counts as a
          // normal completion.
          if (an_ready) begin
            res_flags   <= {an_is_palindrome, an_is_fibonacci, an_is_odd};
            res_timeout <= 1'b0;
            res_valid   <= 1'b1;
            an_enable   <= 1'b0;
            state       <= DONE;
          end else if (timer_expired) begin
            res_flags   <= 3'b000;
            res_timeout <= 1'b1;
            res_valid   <= 1'b1;
            an_enable   <= 1'b0;
            state       <= DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          // IDLE follows DONE so an_enable stays low for two cycles minimum.
          in_ready <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          an_enable <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Counter lanes: total, odd, fib, pal, timeout. Increments are taken from
  // the record registers while DONE is active.
  logic                                 in_done;
  logic [NUM_LANES-1:0]                 lane_inc;
  logic [NUM_LANES-1:0][CNT_WIDTH-1:0]  lane_cnt;

  assign in_done  = (state == DONE);
  assign lane_inc = {NUM_LANES{in_done}} &
                    {res_timeout, res_flags[2], res_flags[1], res_flags[0], 1'b1};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    abc_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clock (clock),
      .reset (reset),
      .clear (clear_counts),
      .inc   (lane_inc[g]),
      .count (lane_cnt[g])
    );
  end

  assign cnt_total   = lane_cnt[0];
  assign cnt_odd     = lane_cnt[1];
  assign cnt_fib     = lane_cnt[2];
  assign cnt_pal     = lane_cnt[3];
  assign cnt_timeout = lane_cnt[4];

endmodule

// File: tb/tb_analyzer_batch_controller.sv
module tb_analyzer_batch_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_number = '0;
  logic        clear_counts = 1'b0;
  logic        an_ready, an_is_odd, an_is_fibonacci, an_is_palindrome;

  logic        in_ready, an_enable, res_valid, res_timeout, busy;
  logic [31:0] an_number, res_number;
  logic [2:0]  res_flags;
  logic [15:0] cnt_total, cnt_odd, cnt_fib, cnt_pal, cnt_timeout;

  // second instance with 2-bit counters, driven by the same stimulus
  logic        in_ready2, an_enable2, res_valid2, res_timeout2, busy2;
  logic [31:0] an_number2, res_number2;
  logic [2:0]  res_flags2;
  logic [1:0]  cnt_total2, cnt_odd2, cnt_fib2, cnt_pal2, cnt_timeout2;

  always #5 clock = ~clock;

  analyzer_batch_controller #(.TIMEOUT_CYCLES(8), .CNT_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_number(in_number),
    .in_ready(in_ready), .clear_counts(clear_counts), .an_number(an_number),
    .an_enable(an_enable), .an_ready(an_ready), .an_is_odd(an_is_odd),
    .an_is_fibonacci(an_is_fibonacci), .an_is_palindrome(an_is_palindrome),
    .res_valid(res_valid), .res_number(res_number), .res_flags(res_flags),
    .res_timeout(res_timeout), .busy(busy), .cnt_total(cnt_total),
    .cnt_odd(cnt_odd), .cnt_fib(cnt_fib), .cnt_pal(cnt_pal),
    .cnt_timeout(cnt_timeout));

  analyzer_batch_controller #(.TIMEOUT_CYCLES(8), .CNT_WIDTH(2)) dut_sat (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_number(in_number),
    .in_ready(in_ready2), .clear_counts(clear_counts), .an_number(an_number2),
    .an_enable(an_enable2), .an_ready(an_ready), .an_is_odd(an_is_odd),
    .an_is_fibonacci(an_is_fibonacci), .an_is_palindrome(an_is_palindrome),
    .res_valid(res_valid2), .res_number(res_number2), .res_flags(res_flags2),
    .res_timeout(res_timeout2), .busy(busy2), .cnt_total(cnt_total2),
    .cnt_odd(cnt_odd2), .cnt_fib(cnt_fib2), .cnt_pal(cnt_pal2),
    .cnt_timeout(cnt_timeout2));

  // ---------------- analyzer stub ----------------
  // Flags per number: {pal, fib, odd}
  function automatic logic [2:0] flags_of(input logic [31:0] n);
    case (n)
      32'd5:   flags_of = 3'b111;
      32'd8:   flags_of = 3'b010;
      32'd12:  flags_of = 3'b000;
      32'd121: flags_of = 3'b101;
      default: flags_of = 3'b111;
    endcase
  endfunction

  int   stub_lat = 5;
  bit   stub_on  = 1'b1;
  int   hi_cnt;
  logic [2:0] stub_flags;

  always @(posedge clock) begin
    if (!an_enable) hi_cnt <= 0;
    else            hi_cnt <= hi_cnt + 1;
  end

  assign stub_flags       = flags_of(an_number);
  assign an_ready         = stub_on && an_enable && (hi_cnt == stub_lat);
  assign an_is_odd        = stub_flags[0];
  assign an_is_fibonacci  = stub_flags[1];
  assign an_is_palindrome = stub_flags[2];

  // ---------------- scoreboard / monitor ----------------
  typedef struct packed {
    logic [31:0] num;
    logic [2:0]  flags;
    logic        to;
  } rec_t;

  rec_t exp_q[$];
  rec_t mon_r;
  int   checks = 0;
  int   errors = 0;
  int   en_len = 0, low_len = 0, last_en_len = 0, min_gap = 99;
  bit   seen_fall = 1'b0;

  always @(negedge clock) begin
    if (res_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_record: got number=%0d flags=%b, required no record",
                 res_number, res_flags);
      end else begin
        mon_r = exp_q.pop_front();
        if ({res_number, res_flags, res_timeout} !== mon_r) begin
          errors++;
          $display("FAIL record: got num=%0d flags=%b to=%b, required num=%0d flags=%b to=%b",
                   res_number, res_flags, res_timeout, mon_r.num, mon_r.flags, mon_r.to);
        end
      end
    end
    if (an_enable) begin
      if (en_len == 0 && seen_fall && low_len < min_gap) min_gap = low_len;
      en_len++;
      low_len = 0;
    end else begin
      if (en_len > 0) begin
        last_en_len = en_len;
        seen_fall   = 1'b1;
      end
      en_len = 0;
      low_len++;
    end
  end

  // ---------------- helpers (stimulus only) ----------------
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    seen_fall = 1'b0;
    min_gap = 99;
  endtask

  // Called at a negedge; returns at the negedge after the accept edge with
  // in_valid still asserted.
  task automatic send(input logic [31:0] n, input bit push, input bit to_exp);
    int g = 0;
    in_valid  = 1'b1;
    in_number = n;
    while (!in_ready && g < 200) begin
      @(negedge clock);
      g++;
    end
    if (g >= 200) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready=%b, required 1", in_ready);
    end
    @(posedge clock);
    if (push) exp_q.push_back(to_exp ? {n, 3'b000, 1'b1} : {n, flags_of(n), 1'b0});
    @(negedge clock);
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 300) begin
      @(negedge clock);
      g++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_wait: busy=%b, required 0", busy);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if ({in_ready, busy, an_enable, res_valid, res_timeout} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy/busy/en/vld/to=%b, required 10000",
               {in_ready, busy, an_enable, res_valid, res_timeout});
    end
    checks++;
    if ({an_number, res_number, res_flags} !== 67'd0) begin
      errors++;
      $display("FAIL reset_data: got an=%0d res=%0d flags=%b, required 0",
               an_number, res_number, res_flags);
    end
    checks++;
    if ({cnt_total, cnt_odd, cnt_fib, cnt_pal, cnt_timeout} !== 80'd0) begin
      errors++;
      $display("FAIL reset_counts: got %0d/%0d/%0d/%0d/%0d, required 0",
               cnt_total, cnt_odd, cnt_fib, cnt_pal, cnt_timeout);
    end
  endtask

  task automatic test_single();
    do_reset();
    stub_on = 1'b1; stub_lat = 5;
    send(32'd5, 1'b1, 1'b0);
    in_valid = 1'b0;
    wait_idle();
    checks++;
    if (last_en_len !== 6) begin
      errors++;
      $display("FAIL single_enable_len: got %0d, required 6", last_en_len);
    end
    checks++;
    if ({cnt_total, cnt_odd, cnt_fib, cnt_pal, cnt_timeout} !==
        {16'd1, 16'd1, 16'd1, 16'd1, 16'd0}) begin
      errors++;
      $display("FAIL single_counts: got %0d/%0d/%0d/%0d/%0d, required 1/1/1/1/0",
               cnt_total, cnt_odd, cnt_fib, cnt_pal, cnt_timeout);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    stub_on = 1'b1; stub_lat = 2;
    send(32'd8, 1'b1, 1'b0);
    send(32'd12, 1'b1, 1'b0);   // changes in_number while in RUN
    send(32'd121, 1'b1, 1'b0);
    in_valid = 1'b0;
    wait_idle();
    checks++;
    if (min_gap !== 2) begin
      errors++;
      $display("FAIL b2b_enable_gap: got %0d, required 2", min_gap);
    end
    checks++;
    if ({cnt_total, cnt_odd, cnt_fib, cnt_pal} !== {16'd3, 16'd1, 16'd1, 16'd1}) begin
      errors++;
      $display("FAIL b2b_counts: got %0d/%0d/%0d/%0d, required 3/1/1/1",
               cnt_total, cnt_odd, cnt_fib, cnt_pal);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    stub_on = 1'b0;
    send(32'd7, 1'b1, 1'b1);
    in_valid = 1'b0;
    wait_idle();
    checks++;
    if (last_en_len !== 8) begin
      errors++;
      $display("FAIL timeout_enable_len: got %0d, required 8", last_en_len);
    end
    checks++;
    if ({cnt_total, cnt_timeout, cnt_odd} !== {16'd1, 16'd1, 16'd0}) begin
      errors++;
      $display("FAIL timeout_counts: got total=%0d to=%0d odd=%0d, required 1/1/0",
               cnt_total, cnt_timeout, cnt_odd);
    end
    stub_on = 1'b1;
  endtask

  task automatic test_clear_collision();
    int g = 0;
    do_reset();
    stub_on = 1'b1; stub_lat = 1;
    for (int i = 0; i < 4; i++) begin
      send(32'd30 + 32'(i), 1'b1, 1'b0);
      in_valid = 1'b0;
      wait_idle();
    end
    checks++;
    if (cnt_total !== 16'd4) begin
      errors++;
      $display("FAIL clear_pre_total: got %0d, required 4", cnt_total);
    end
    send(32'd40, 1'b1, 1'b0);
    in_valid = 1'b0;
    while (!res_valid && g < 50) begin
      @(negedge clock);
      g++;
    end
    clear_counts = 1'b1;
    @(negedge clock);
    clear_counts = 1'b0;
    checks++;
    if ({cnt_total, cnt_odd, cnt_fib, cnt_pal, cnt_timeout} !== 80'd0) begin
      errors++;
      $display("FAIL clear_counts: got %0d/%0d/%0d/%0d/%0d, required 0",
               cnt_total, cnt_odd, cnt_fib, cnt_pal, cnt_timeout);
    end
    wait_idle();
    send(32'd41, 1'b1, 1'b0);
    in_valid = 1'b0;
    wait_idle();
    checks++;
    if ({cnt_total, cnt_odd} !== {16'd1, 16'd1}) begin
      errors++;
      $display("FAIL clear_post: got total=%0d odd=%0d, required 1/1", cnt_total, cnt_odd);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    stub_on = 1'b1; stub_lat = 3;
    for (int i = 0; i < 5; i++) begin
      send(32'd50 + 32'(i), 1'b1, 1'b0);
      in_valid = 1'b0;
      wait_idle();
    end
    checks++;
    if ({cnt_total2, cnt_odd2, cnt_fib2, cnt_pal2, cnt_timeout2} !== 10'b11_11_11_11_00) begin
      errors++;
      $display("FAIL sat_counts: got %0d/%0d/%0d/%0d/%0d, required 3/3/3/3/0",
               cnt_total2, cnt_odd2, cnt_fib2, cnt_pal2, cnt_timeout2);
    end
    checks++;
    if (cnt_total !== 16'd5) begin
      errors++;
      $display("FAIL sat_wide_total: got %0d, required 5", cnt_total);
    end
  endtask

  // Counters are non-zero on entry (left from the saturation scenario).
  task automatic test_reset_mid_run();
    stub_on = 1'b0;
    send(32'd9, 1'b0, 1'b0);     // returns in RUN cycle 1
    in_valid = 1'b0;
    @(negedge clock);            // RUN cycle 2
    @(negedge clock);            // RUN cycle 3
    checks++;
    if (an_enable !== 1'b1) begin
      errors++;
      $display("FAIL midrun_pre_enable: got %b, required 1", an_enable);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if ({an_enable, busy, in_ready, res_valid} !== 4'b0010) begin
      errors++;
      $display("FAIL midrun_ctrl: got en/busy/rdy/vld=%b, required 0010",
               {an_enable, busy, in_ready, res_valid});
    end
    checks++;
    if ({cnt_total, cnt_odd, cnt_fib, cnt_pal, cnt_timeout} !== 80'd0) begin
      errors++;
      $display("FAIL midrun_counts: got %0d/%0d/%0d/%0d/%0d, required 0",
               cnt_total, cnt_odd, cnt_fib, cnt_pal, cnt_timeout);
    end
    repeat (15) @(negedge clock);  // any stray record is caught by the monitor
    checks++;
    if ({busy, an_enable} !== 2'b00) begin
      errors++;
      $display("FAIL midrun_after: got busy/en=%b, required 00", {busy, an_enable});
    end
    stub_on = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_clear_collision();
    test_saturation();
    test_reset_mid_run();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_records: got %0d outstanding, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
